// File: rtl/tlb_refill_arbiter.sv
// tlb_refill_arbiter: shares one hardware page-table walker between the ITLB and the DTLB.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   ITLBMissF/ITLBVAdr   instruction TLB miss (level) and its virtual address
//   DTLBMissM/DTLBVAdr   data TLB miss (level) and its virtual address
//   DTLBWriteAccess      data miss is a store/AMO
//   TLBFlush             sfence.vma / satp write flush
//   WalkReq/WalkVAdr     walk request and registered address to the walker
//   WalkIsInstr          walk serves the ITLB (1) or the DTLB (0)
//   WalkWriteAccess      registered store/AMO flag (0 for instruction walks)
//   WalkDone/WalkFault   walker completion pulse and fault flag
//   WalkPTE/WalkPageType leaf PTE and page level, valid with WalkDone
//   DisableTranslation   high while a walk is outstanding
//   ITLBWrite/DTLBWrite  single-cycle TLB write pulses
//   TLBWritePTE          registered PTE for the write
//   TLBWritePageType     registered page type for the write
//   I/DTLBRefillFault    single-cycle refill fault pulses
//   Busy                 arbiter is not idle
module tlb_refill_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned PTYPE_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ITLBMissF,
  input  logic [XLEN-1:0]       ITLBVAdr,
  input  logic                  DTLBMissM,
  input  logic [XLEN-1:0]       DTLBVAdr,
  input  logic                  DTLBWriteAccess,
  input  logic                  TLBFlush,
  output logic                  WalkReq,
  output logic [XLEN-1:0]       WalkVAdr,
  output logic                  WalkIsInstr,
  output logic                  WalkWriteAccess,
  input  logic                  WalkDone,
  input  logic                  WalkFault,
  input  logic [XLEN-1:0]       WalkPTE,
  input  logic [PTYPE_BITS-1:0] WalkPageType,
  output logic                  DisableTranslation,
  output logic                  ITLBWrite,
  output logic                  DTLBWrite,
  output logic [XLEN-1:0]       TLBWritePTE,
  output logic [PTYPE_BITS-1:0] TLBWritePageType,
  output logic                  ITLBRefillFault,
  output logic                  DTLBRefillFault,
  output logic                  Busy
);

  typedef enum logic [1:0] {StIdle, StWalk, StWrite, StDrain} state_e;

  state_e                r_state;
  logic                  r_last_grant_d;
  logic [XLEN-1:0]       r_walk_vadr;
  logic                  r_walk_is_instr;
  logic                  r_walk_write_access;
  logic [XLEN-1:0]       r_pte;
  logic [PTYPE_BITS-1:0] r_ptype;

  logic w_any_miss;
  logic w_grant_d;
  logic w_walk_fault;
  logic w_write;

  assign w_any_miss = ITLBMissF | DTLBMissM;
  // D wins when it is the only requester, or on a tie when I was granted last.
  assign w_grant_d  = DTLBMissM & (~ITLBMissF | ~r_last_grant_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state             <= StIdle;
      r_last_grant_d      <= 1'b0;
      r_walk_vadr         <= '0;
      r_walk_is_instr     <= 1'b0;
      r_walk_write_access <= 1'b0;
      r_pte               <= '0;
      r_ptype             <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!TLBFlush && w_any_miss) begin
            r_walk_vadr         <= w_grant_d ? DTLBVAdr : ITLBVAdr;
            r_walk_is_instr     <= ~w_grant_d;
            r_walk_write_access <= w_grant_d & DTLBWriteAccess;
            r_last_grant_d      <= w_grant_d;
            r_state             <= StWalk;
          end
        end
        StWalk: begin
          if (WalkDone) begin
            // A flush coinciding with completion discards the result entirely.
            if (!TLBFlush && !WalkFault) begin
              r_pte   <= WalkPTE;
              r_ptype <= WalkPageType;
              r_state <= StWrite;
            end else begin
              r_state <= StIdle;
            end
          end else if (TLBFlush) begin
            r_state <= StDrain;
          end
        end
        StWrite: r_state <= StIdle;
        // The walker cannot be cancelled, so wait for it and drop the result.
        StDrain: begin
          if (WalkDone) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_walk_fault = (r_state == StWalk) & WalkDone & WalkFault & ~TLBFlush;
  assign w_write      = (r_state == StWrite) & ~TLBFlush;

  assign WalkReq            = (r_state == StWalk) | (r_state == StDrain);
  assign DisableTranslation = WalkReq;
  assign Busy               = (r_state != StIdle);
  assign WalkVAdr           = r_walk_vadr;
  assign WalkIsInstr        = r_walk_is_instr;
  assign WalkWriteAccess    = r_walk_write_access;
  assign TLBWritePTE        = r_pte;
  assign TLBWritePageType   = r_ptype;
  assign ITLBWrite          = w_write & r_walk_is_instr;
  assign DTLBWrite          = w_write & ~r_walk_is_instr;
  assign ITLBRefillFault    = w_walk_fault & r_walk_is_instr;
  assign DTLBRefillFault    = w_walk_fault & ~r_walk_is_instr;

endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// Self-checking bench for tlb_refill_arbiter: a directed vector table, hand-written
// flush/reset corner sequences and randomized traffic against a transaction-level model.
module tb_tlb_refill_arbiter;

  localparam int unsigned XLEN = 64;
  localparam int unsigned PT   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ITLBMissF, DTLBMissM, DTLBWriteAccess, TLBFlush;
  logic [XLEN-1:0] ITLBVAdr, DTLBVAdr, WalkPTE;
  logic            WalkDone, WalkFault;
  logic [PT-1:0]   WalkPageType;
  logic            WalkReq, WalkIsInstr, WalkWriteAccess, DisableTranslation;
  logic [XLEN-1:0] WalkVAdr, TLBWritePTE;
  logic [PT-1:0]   TLBWritePageType;
  logic            ITLBWrite, DTLBWrite, ITLBRefillFault, DTLBRefillFault, Busy;

  always #5 clk = ~clk;

  tlb_refill_arbiter #(.XLEN(XLEN), .PTYPE_BITS(PT)) dut (
    .clk(clk), .reset(reset),
    .ITLBMissF(ITLBMissF), .ITLBVAdr(ITLBVAdr),
    .DTLBMissM(DTLBMissM), .DTLBVAdr(DTLBVAdr), .DTLBWriteAccess(DTLBWriteAccess),
    .TLBFlush(TLBFlush),
    .WalkReq(WalkReq), .WalkVAdr(WalkVAdr), .WalkIsInstr(WalkIsInstr),
    .WalkWriteAccess(WalkWriteAccess),
    .WalkDone(WalkDone), .WalkFault(WalkFault), .WalkPTE(WalkPTE),
    .WalkPageType(WalkPageType),
    .DisableTranslation(DisableTranslation),
    .ITLBWrite(ITLBWrite), .DTLBWrite(DTLBWrite),
    .TLBWritePTE(TLBWritePTE), .TLBWritePageType(TLBWritePageType),
    .ITLBRefillFault(ITLBRefillFault), .DTLBRefillFault(DTLBRefillFault),
    .Busy(Busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: one outstanding walk transaction plus a pending-write flag.
  bit              m_walking, m_aborted, m_write_due, m_instr, m_wa, m_last_d;
  logic [XLEN-1:0] m_vadr, m_pte;
  logic [PT-1:0]   m_ptype;

  task automatic model_reset();
    m_walking = 0; m_aborted = 0; m_write_due = 0; m_instr = 0; m_wa = 0; m_last_d = 0;
    m_vadr = '0; m_pte = '0; m_ptype = '0;
  endtask

  task automatic model_check();
    bit fault_hit;
    bit write_hit;
    fault_hit = m_walking && !m_aborted && WalkDone && WalkFault && !TLBFlush;
    write_hit = m_write_due && !TLBFlush;
    chk("WalkReq", WalkReq, m_walking);
    chk("DisableTranslation", DisableTranslation, m_walking);
    chk("Busy", Busy, m_walking | m_write_due);
    chk("ITLBWrite", ITLBWrite, write_hit & m_instr);
    chk("DTLBWrite", DTLBWrite, write_hit & !m_instr);
    chk("ITLBRefillFault", ITLBRefillFault, fault_hit & m_instr);
    chk("DTLBRefillFault", DTLBRefillFault, fault_hit & !m_instr);
    chk("WalkVAdr", WalkVAdr, m_vadr);
    chk("WalkIsInstr", WalkIsInstr, m_instr);
    chk("WalkWriteAccess", WalkWriteAccess, m_wa);
    chk("TLBWritePTE", TLBWritePTE, m_pte);
    chk("TLBWritePageType", TLBWritePageType, m_ptype);
  endtask

  task automatic model_step();
    bit gd;
    if (m_write_due) begin
      m_write_due = 0;
    end else if (m_walking) begin
      if (WalkDone) begin
        if (!m_aborted && !TLBFlush && !WalkFault) begin
          m_write_due = 1; m_pte = WalkPTE; m_ptype = WalkPageType;
        end
        m_walking = 0; m_aborted = 0;
      end else if (TLBFlush) begin
        m_aborted = 1;
      end
    end else if (!TLBFlush && (ITLBMissF || DTLBMissM)) begin
      gd = (ITLBMissF && DTLBMissM) ? !m_last_d : DTLBMissM;
      m_vadr = gd ? DTLBVAdr : ITLBVAdr;
      m_instr = !gd;
      m_wa = gd & DTLBWriteAccess;
      m_last_d = gd;
      m_walking = 1;
    end
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cycle();
    #4;
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ITLBMissF = 0; ITLBVAdr = '0; DTLBMissM = 0; DTLBVAdr = '0; DTLBWriteAccess = 0;
    TLBFlush = 0; WalkDone = 0; WalkFault = 0; WalkPTE = '0; WalkPageType = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  typedef struct {
    logic            imiss;
    logic [XLEN-1:0] ivadr;
    logic            dmiss;
    logic [XLEN-1:0] dvadr;
    logic            dwa;
    logic            done;
    logic            fault;
    logic [XLEN-1:0] pte;
    logic [PT-1:0]   ptype;
    logic            e_req, e_busy, e_iw, e_dw, e_if, e_df;
    logic [XLEN-1:0] e_vadr;
    logic            e_instr, e_wa;
    logic [XLEN-1:0] e_pte;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [XLEN-1:0] va_d, pte1, va_i;
    va_d = 64'h8000_1234;
    pte1 = 64'h2000_00CF;
    va_i = 64'h4000;
    // Single D miss, done 5 cycles in, then an I walk that faults.
    vt[0]  = '{0, 0, 1, va_d, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0,    0, 0, 0};
    vt[1]  = '{0, 0, 1, va_d, 1, 0, 0, 0, 0,    1, 1, 0, 0, 0, 0, va_d, 0, 1, 0};
    vt[2]  = vt[1];
    vt[3]  = vt[1];
    vt[4]  = vt[1];
    vt[5]  = '{0, 0, 1, va_d, 1, 1, 0, pte1, 0, 1, 1, 0, 0, 0, 0, va_d, 0, 1, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 1, 0, 1, 0, 0, va_d, 0, 1, pte1};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, va_d, 0, 1, pte1};
    vt[8]  = '{1, va_i, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, va_d, 0, 1, pte1};
    vt[9]  = '{1, va_i, 0, 0, 0, 0, 0, 0, 0,    1, 1, 0, 0, 0, 0, va_i, 1, 0, pte1};
    vt[10] = '{1, va_i, 0, 0, 0, 1, 1, 0, 0,    1, 1, 0, 0, 1, 0, va_i, 1, 0, pte1};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, va_i, 1, 0, pte1};

    idle_inputs();
    do_reset();
    chk("reset.WalkReq", WalkReq, 0);
    chk("reset.Busy", Busy, 0);

    for (int i = 0; i < 12; i++) begin
      ITLBMissF = vt[i].imiss; ITLBVAdr = vt[i].ivadr;
      DTLBMissM = vt[i].dmiss; DTLBVAdr = vt[i].dvadr; DTLBWriteAccess = vt[i].dwa;
      TLBFlush = 0; WalkDone = vt[i].done; WalkFault = vt[i].fault;
      WalkPTE = vt[i].pte; WalkPageType = vt[i].ptype;
      #4;
      chk($sformatf("v%0d.WalkReq", i), WalkReq, vt[i].e_req);
      chk($sformatf("v%0d.Busy", i), Busy, vt[i].e_busy);
      chk($sformatf("v%0d.ITLBWrite", i), ITLBWrite, vt[i].e_iw);
      chk($sformatf("v%0d.DTLBWrite", i), DTLBWrite, vt[i].e_dw);
      chk($sformatf("v%0d.ITLBRefillFault", i), ITLBRefillFault, vt[i].e_if);
      chk($sformatf("v%0d.DTLBRefillFault", i), DTLBRefillFault, vt[i].e_df);
      chk($sformatf("v%0d.WalkVAdr", i), WalkVAdr, vt[i].e_vadr);
      chk($sformatf("v%0d.WalkIsInstr", i), WalkIsInstr, vt[i].e_instr);
      chk($sformatf("v%0d.WalkWriteAccess", i), WalkWriteAccess, vt[i].e_wa);
      chk($sformatf("v%0d.TLBWritePTE", i), TLBWritePTE, vt[i].e_pte);
      @(posedge clk);
      #1;
    end

    // Simultaneous misses out of reset: D first, then I after one idle cycle.
    do_reset();
    ITLBMissF = 1; ITLBVAdr = 64'h1000; DTLBMissM = 1; DTLBVAdr = 64'h2000;
    cycle();
    chk("sim.first_is_d", WalkIsInstr, 0);
    chk("sim.first_vadr", WalkVAdr, 64'h2000);
    cycle();
    WalkDone = 1; WalkPTE = 64'hAAA; cycle();
    WalkDone = 0; cycle();
    chk("sim.idle_gap", Busy, 0);
    cycle();
    chk("sim.second_vadr", WalkVAdr, 64'h1000);
    chk("sim.second_is_i", WalkIsInstr, 1);
    DTLBMissM = 0; WalkDone = 1; WalkPTE = 64'hBBB; cycle();
    WalkDone = 0; ITLBMissF = 0; cycle();
    cycle();

    // Flush mid-walk: drain until the walker finishes; requester drops its miss.
    do_reset();
    DTLBMissM = 1; DTLBVAdr = 64'h3000; cycle();
    DTLBMissM = 0; cycle();
    TLBFlush = 1; cycle();
    TLBFlush = 0; cycle();
    TLBFlush = 1; cycle();
    TLBFlush = 0; WalkDone = 1; WalkFault = 1; cycle();
    WalkDone = 0; WalkFault = 0; cycle();
    chk("drain.idle", Busy, 0);

    // Flush coincident with WalkDone.
    ITLBMissF = 1; ITLBVAdr = 64'h6000; cycle();
    ITLBMissF = 0; cycle();
    WalkDone = 1; TLBFlush = 1; WalkPTE = 64'hCCC; cycle();
    WalkDone = 0; TLBFlush = 0; cycle();

    // Flush during WRITE.
    DTLBMissM = 1; DTLBVAdr = 64'h7000; cycle();
    DTLBMissM = 0; WalkDone = 1; WalkPTE = 64'hDDD; cycle();
    WalkDone = 0; TLBFlush = 1; cycle();
    TLBFlush = 0; cycle();

    // Reset mid-walk clears the walk request before the next edge.
    do_reset();
    DTLBMissM = 1; DTLBVAdr = 64'h5000; cycle();
    cycle();
    #2;
    reset = 1;
    #1;
    chk("rst.WalkReq", WalkReq, 0);
    chk("rst.DisableTranslation", DisableTranslation, 0);
    chk("rst.Busy", Busy, 0);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    cycle();
    chk("rst.regrant_vadr", WalkVAdr, 64'h5000);
    chk("rst.regrant_req", WalkReq, 1);
    DTLBMissM = 0; WalkDone = 1; cycle();
    WalkDone = 0; cycle();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ITLBMissF = ($urandom_range(0, 2) == 0);
      DTLBMissM = ($urandom_range(0, 2) == 0);
      ITLBVAdr = {$urandom, $urandom};
      DTLBVAdr = {$urandom, $urandom};
      DTLBWriteAccess = $urandom_range(0, 1);
      TLBFlush = ($urandom_range(0, 11) == 0);
      WalkDone = ($urandom_range(0, 3) == 0);
      WalkFault = ($urandom_range(0, 3) == 0);
      WalkPTE = {$urandom, $urandom};
      WalkPageType = PT'($urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_refill_arbiter.md
Name: tlb_refill_arbiter

Overview:
- Shares one hardware page-table walker between the instruction MMU's TLB and the data MMU's TLB.
- Accepts TLB-miss requests from both, grants one walk at a time using round-robin priority, and holds translation disabled during the walk.
- On completion, either sequences a single TLB write into the requesting TLB or reports a refill fault.
- A TLB flush that arrives mid-walk aborts the refill cleanly.

Parameters:
XLEN, 64, virtual address and PTE width
PTYPE_BITS, 2, page-type width (matches TLB PageTypeWriteVal)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ITLBMissF  in  1  instruction TLB miss, level (held until serviced)
ITLBVAdr  in  XLEN  instruction virtual address that missed
DTLBMissM  in  1  data TLB miss, level
DTLBVAdr  in  XLEN  data virtual address that missed
DTLBWriteAccess  in  1  data miss is a store/AMO
TLBFlush  in  1  sfence.vma / satp write flush
WalkReq  out  1  walk request to HPTW, held high until WalkDone
WalkVAdr  out  XLEN  registered address being walked
WalkIsInstr  out  1  walk serves ITLB (1) or DTLB (0)
WalkWriteAccess  out  1  registered DTLBWriteAccess (0 for instruction walks)
WalkDone  in  1  walker finished, single-cycle pulse
WalkFault  in  1  walk ended in page fault; valid with WalkDone
WalkPTE  in  XLEN  leaf PTE; valid with WalkDone
WalkPageType  in  PTYPE_BITS  page level of leaf; valid with WalkDone
DisableTranslation  out  1  high while WalkReq is high
ITLBWrite  out  1  write pulse to ITLB
DTLBWrite  out  1  write pulse to DTLB
TLBWritePTE  out  XLEN  registered PTE for the write
TLBWritePageType  out  PTYPE_BITS  registered page type
ITLBRefillFault  out  1  one-cycle fault pulse to the fetch stage
DTLBRefillFault  out  1  one-cycle fault pulse to the memory stage
Busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WALK, WRITE, DRAIN.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs and registers are 0, including LastGrantD, which is 0 so the data side wins the first tie.
- IDLE, no TLBFlush, at least one miss asserted:
  - Grant selection: if only one miss is asserted, grant it. If both are asserted, grant the side opposite LastGrantD (LastGrantD=0 grants D; LastGrantD=1 grants I).
  - On that edge, capture WalkVAdr, WalkIsInstr and WalkWriteAccess, update LastGrantD, and go to WALK.
  - Latency from miss assertion to WalkReq high is 1 cycle.
- IDLE with TLBFlush: capture nothing that cycle and stay in IDLE.
- WALK:
  - WalkReq=1 and DisableTranslation=1.
  - The captured registers are stable until exit.
  - On WalkDone with ~WalkFault: register WalkPTE and WalkPageType, go to WRITE.
  - On WalkDone with WalkFault: assert ITLBRefillFault or DTLBRefillFault (per WalkIsInstr) combinationally that cycle only, then go to IDLE. No write occurs.
  - TLBFlush without WalkDone: go to DRAIN.
  - TLBFlush in the same cycle as WalkDone: discard the result (no write, no fault), go to IDLE.
- DRAIN:
  - WalkReq stays high because the walker must finish.
  - WalkDone discards the result and goes to IDLE. No write and no fault, regardless of WalkFault.
  - Further TLBFlush pulses are ignored.
- WRITE (exactly 1 cycle):
  - Assert ITLBWrite or DTLBWrite (per WalkIsInstr) with TLBWritePTE/TLBWritePageType, then go to IDLE.
  - TLBFlush in this cycle suppresses the write pulse; still go to IDLE.
- After WRITE or a fault, IDLE lasts at least 1 cycle before the next grant. This lets the TLB's miss signal drop after the write.
- A requester that drops its miss mid-walk (e.g., pipeline flush) does not abort the walk; the refill still completes and the write is performed.
- ITLBWrite and DTLBWrite are never high together, and neither is high outside WRITE.
- Fault pulses are never high outside WALK.

Test Plan:
- Single D miss: DTLBMissM=1, DTLBVAdr=0x80001234, DTLBWriteAccess=1; WalkDone after 5 cycles with WalkPTE=0x200000CF, WalkPageType=0 -> WalkReq high 1 cycle after the miss, WalkVAdr=0x80001234, WalkWriteAccess=1; one DTLBWrite pulse with TLBWritePTE=0x200000CF; ITLBWrite stays 0.
- Simultaneous misses, I=0x1000 and D=0x2000, out of reset -> D walked first; after its WRITE and 1 IDLE cycle, I is walked with WalkVAdr=0x1000 and WalkIsInstr=1; LastGrantD toggles each grant.
- Fault: I miss, WalkDone with WalkFault=1 -> ITLBRefillFault high exactly 1 cycle, no ITLBWrite or DTLBWrite, Busy=0 on the next cycle.
- Flush mid-walk: TLBFlush 2 cycles into WALK, WalkDone 3 cycles later -> WalkReq stays high through DRAIN; no write and no fault; IDLE afterwards.
- Flush coincident with WalkDone, and flush during WRITE -> no write pulse in either case.
- Reset asserted mid-WALK -> WalkReq, DisableTranslation and Busy go to 0 asynchronously, before the next clock edge; the next D miss after reset is granted normally.
